// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit path.
//   UART_DATA_W      : width of one UART data byte.
//   uart_tx_state_e  : launch sequencer state encoding, also exported on the
//                      top-level debug port so checkers can bind to it.
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BUSY = 2'd1,
        GAP       = 2'd2,
        WAIT_DONE = 2'd3
    } uart_tx_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// ---------------------------------------------------------------------------
// uart_sync_fifo
// Single-clock circular byte FIFO with registered status.
//
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   wr_en        : push wr_data (ignored while full)
//   wr_data      : byte to push
//   rd_en        : pop the head (ignored while empty)
//   rd_data      : current head entry (combinational read of rd_ptr)
//   full, empty  : registered status, valid the cycle after a push/pop
//   level        : registered entry count, 0..DEPTH
//
// Pointers are ADDR_W bits and wrap naturally modulo DEPTH; the occupancy is
// a separate counter so full and empty never need a pointer-compare trick.
// ---------------------------------------------------------------------------
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int DATA_W = UART_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   level
);

    localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   level_next;
    logic              wr_ok;
    logic              rd_ok;

    // A write while full is dropped even if a pop happens the same cycle.
    assign wr_ok   = wr_en & ~full;
    assign rd_ok   = rd_en & ~empty;
    assign rd_data = mem[rd_ptr];

    always_comb begin
        level_next = level;
        case ({wr_ok, rd_ok})
            2'b10:   level_next = level + (ADDR_W+1)'(1);
            2'b01:   level_next = level - (ADDR_W+1)'(1);
            default: level_next = level;
        endcase
    end

    // Storage carries no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            level <= level_next;
            full  <= (level_next == FULL_LVL);
            empty <= (level_next == '0);
        end
    end

endmodule

// File: rtl/uart_tx_queue.sv
// ---------------------------------------------------------------------------
// uart_tx_queue
// Byte queue plus launch sequencer in front of an edge-triggered UART
// transmitter. Producers only watch `full`; the sequencer drains the FIFO
// one byte per frame by raising tx_en and following uart_tx_busy.
//
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   wr_en/wr_data : producer push (dropped while full)
//   full, empty   : registered FIFO status
//   level         : registered FIFO entry count, 0..DEPTH
//   tx_en         : launch request, a rising edge starts one frame
//   tx_din        : byte presented to the transmitter
//   uart_tx_busy  : transmitter busy flag
//   retry         : one-cycle pulse when a launch timed out and is re-armed
//   ovf_cnt       : saturating count of dropped writes, only when
//                   UART_TX_QUEUE_OVF_CNT_EN is defined
//   dbg_state     : current sequencer state
//
// Handshake: a byte is accepted on any clock edge where wr_en=1 and full=0;
// no other qualifier exists. On the transmitter side tx_din is stable from
// the cycle tx_en rises until the next pop, and tx_en is always low for at
// least one cycle between rising edges.
//
// Build option: `define UART_TX_QUEUE_OVF_CNT_EN adds the ovf_cnt port.
// ---------------------------------------------------------------------------
module uart_tx_queue
    import uart_pkg::*;
#(
    parameter int DEPTH        = 16,
    parameter int ADDR_W       = 4,
    parameter int BUSY_TIMEOUT = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [UART_DATA_W-1:0] wr_data,
    output logic                   full,
    output logic                   empty,
    output logic [ADDR_W:0]        level,
    output logic                   tx_en,
    output logic [UART_DATA_W-1:0] tx_din,
    input  logic                   uart_tx_busy,
    output logic                   retry,
`ifdef UART_TX_QUEUE_OVF_CNT_EN
    output logic [7:0]             ovf_cnt,
`endif
    output uart_tx_state_e         dbg_state
);

    localparam logic [7:0] TIMEOUT_LAST = 8'(BUSY_TIMEOUT - 1);

    uart_tx_state_e         state;
    uart_tx_state_e         state_next;
    logic [7:0]             tmo_cnt;
    logic [7:0]             tmo_cnt_next;
    logic                   tx_en_next;
    logic                   retry_next;
    logic                   pop;
    logic [UART_DATA_W-1:0] head;

    uart_sync_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (UART_DATA_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (pop),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .level   (level)
    );

    assign dbg_state = state;

    always_comb begin
        state_next   = state;
        tmo_cnt_next = tmo_cnt;
        tx_en_next   = tx_en;
        retry_next   = 1'b0;
        pop          = 1'b0;
        case (state)
            IDLE: begin
                if (!empty && !uart_tx_busy) begin
                    pop          = 1'b1;
                    tx_en_next   = 1'b1;
                    tmo_cnt_next = '0;
                    state_next   = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                if (uart_tx_busy) begin
                    tx_en_next = 1'b0;
                    state_next = WAIT_DONE;
                end else if (tmo_cnt == TIMEOUT_LAST) begin
                    // Launch was not acknowledged: drop tx_en for the GAP
                    // cycle so the re-launch is a fresh rising edge.
                    tx_en_next = 1'b0;
                    retry_next = 1'b1;
                    state_next = GAP;
                end else begin
                    tmo_cnt_next = tmo_cnt + 8'd1;
                end
            end
            GAP: begin
                tx_en_next   = 1'b1;
                tmo_cnt_next = '0;
                state_next   = WAIT_BUSY;
            end
            WAIT_DONE: begin
                if (!uart_tx_busy) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            tmo_cnt <= '0;
            tx_en   <= 1'b0;
            tx_din  <= '0;
            retry   <= 1'b0;
        end else begin
            state   <= state_next;
            tmo_cnt <= tmo_cnt_next;
            tx_en   <= tx_en_next;
            retry   <= retry_next;
            // tx_din only changes on a pop, so it is stable across retries.
            if (pop) begin
                tx_din <= head;
            end
        end
    end

`ifdef UART_TX_QUEUE_OVF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_cnt <= '0;
        end else if (wr_en && full && (ovf_cnt != 8'hFF)) begin
            ovf_cnt <= ovf_cnt + 8'd1;
        end
    end
`endif

endmodule
